// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: next-select, condition select,
// MIPS opcode/funct values and the microstates the decoder dispatches to.
package microseq_pkg;

   localparam int unsigned STATE_W = 7;
   localparam int unsigned SEL_W   = 3;
   localparam int unsigned COND_W  = 2;
   localparam int unsigned OP_W    = 6;

   localparam logic [STATE_W-1:0] FETCH_STATE   = 7'd0;
   localparam logic [STATE_W-1:0] ILLEGAL_STATE = 7'd5;

   localparam logic [SEL_W-1:0] NS_DECODE = 3'b000;
   localparam logic [SEL_W-1:0] NS_FETCH  = 3'b001;
   localparam logic [SEL_W-1:0] NS_CR     = 3'b010;
   localparam logic [SEL_W-1:0] NS_INC    = 3'b011;
   localparam logic [SEL_W-1:0] NS_BRANCH = 3'b100;
   localparam logic [SEL_W-1:0] NS_WAIT   = 3'b101;
   localparam logic [SEL_W-1:0] NS_CALL   = 3'b110;
   localparam logic [SEL_W-1:0] NS_RET    = 3'b111;

   localparam logic [COND_W-1:0] CS_MOC  = 2'b00;
   localparam logic [COND_W-1:0] CS_ZERO = 2'b01;
   localparam logic [COND_W-1:0] CS_NEG  = 2'b10;
   localparam logic [COND_W-1:0] CS_ONE  = 2'b11;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;

   localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
   localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
   localparam logic [OP_W-1:0] FN_AND  = 6'h24;
   localparam logic [OP_W-1:0] FN_OR   = 6'h25;
   localparam logic [OP_W-1:0] FN_JR   = 6'h08;

   localparam logic [STATE_W-1:0] ST_ADDU  = 7'd17;
   localparam logic [STATE_W-1:0] ST_SUBU  = 7'd18;
   localparam logic [STATE_W-1:0] ST_AND   = 7'd23;
   localparam logic [STATE_W-1:0] ST_OR    = 7'd25;
   localparam logic [STATE_W-1:0] ST_JR    = 7'd30;
   localparam logic [STATE_W-1:0] ST_LW    = 7'd7;
   localparam logic [STATE_W-1:0] ST_SW    = 7'd9;
   localparam logic [STATE_W-1:0] ST_BEQ   = 7'd16;
   localparam logic [STATE_W-1:0] ST_ADDIU = 7'd6;
   localparam logic [STATE_W-1:0] ST_LUI   = 7'd31;
   localparam logic [STATE_W-1:0] ST_J     = 7'd12;

endpackage

// File: rtl/microsequencer_if.sv
// Microinstruction fields, status flags and IR slices into the sequencer,
// plus the current microstate out to the microstore.
interface microsequencer_if;
   import microseq_pkg::*;

   logic [SEL_W-1:0]   nextSel;
   logic [STATE_W-1:0] crAddr;
   logic [COND_W-1:0]  condSel;
   logic               condInv;
   logic               moc;
   logic               zeroFlag;
   logic               negFlag;
   logic [OP_W-1:0]    opcode;
   logic [OP_W-1:0]    funct;
   logic [STATE_W-1:0] currentState;

   modport master (
      output nextSel, crAddr, condSel, condInv, moc, zeroFlag, negFlag, opcode, funct,
      input  currentState
   );

   modport slave (
      input  nextSel, crAddr, condSel, condInv, moc, zeroFlag, negFlag, opcode, funct,
      output currentState
   );
endinterface

// File: rtl/instr_decoder.sv
// Combinational opcode/funct -> dispatch microstate; unmapped encodings go to ILLEGAL_STATE.
module instr_decoder
   import microseq_pkg::*;
(
   input  logic [OP_W-1:0]    opcode,
   input  logic [OP_W-1:0]    funct,
   output logic [STATE_W-1:0] state
);

   always_comb begin
      state = ILLEGAL_STATE;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: state = ST_ADDU;
               FN_SUBU: state = ST_SUBU;
               FN_AND:  state = ST_AND;
               FN_OR:   state = ST_OR;
               FN_JR:   state = ST_JR;
               default: state = ILLEGAL_STATE;
            endcase
         end
         OP_LW:    state = ST_LW;
         OP_SW:    state = ST_SW;
         OP_BEQ:   state = ST_BEQ;
         OP_ADDIU: state = ST_ADDIU;
         OP_LUI:   state = ST_LUI;
         OP_J:     state = ST_J;
         default:  state = ILLEGAL_STATE;
      endcase
   end

endmodule

// File: rtl/microsequencer.sv
// Microprogram next-state generator owning the microstore address register.
// Optional one-deep call/return stack enabled by MICROSEQ_RETURN_EN.
module microsequencer
   import microseq_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   microsequencer_if.slave  bus
);

   logic [STATE_W-1:0] decoded;
   logic [STATE_W-1:0] inc;
   logic [STATE_W-1:0] next_state;
   logic               cond_raw;
   logic               cond;

   instr_decoder u_decoder (
      .opcode (bus.opcode),
      .funct  (bus.funct),
      .state  (decoded)
   );

   assign inc = bus.currentState + STATE_W'(1);

   always_comb begin
      cond_raw = 1'b1;
      case (bus.condSel)
         CS_MOC:  cond_raw = bus.moc;
         CS_ZERO: cond_raw = bus.zeroFlag;
         CS_NEG:  cond_raw = bus.negFlag;
         default: cond_raw = 1'b1;
      endcase
      cond = cond_raw ^ bus.condInv;
   end

`ifdef MICROSEQ_RETURN_EN
   logic [STATE_W-1:0] returnReg;

   // Single return slot; a call overwrites it, so nesting is not supported.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         returnReg <= '0;
      else if (bus.nextSel == NS_CALL)
         returnReg <= inc;
   end
`endif

   // Unlisted selects (including X in simulation) fall back to fetch.
   always_comb begin
      next_state = FETCH_STATE;
      case (bus.nextSel)
         NS_DECODE: next_state = decoded;
         NS_FETCH:  next_state = FETCH_STATE;
         NS_CR:     next_state = bus.crAddr;
         NS_INC:    next_state = inc;
         NS_BRANCH: next_state = cond ? bus.crAddr : inc;
         NS_WAIT:   next_state = cond ? inc : bus.currentState;
`ifdef MICROSEQ_RETURN_EN
         NS_CALL:   next_state = bus.crAddr;
         NS_RET:    next_state = returnReg;
`endif
         default:   next_state = FETCH_STATE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bus.currentState <= FETCH_STATE;
      else
         bus.currentState <= next_state;
   end

endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for microsequencer and its instruction decoder.
module tb_microsequencer;
   import microseq_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   microsequencer_if bus ();

   microsequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [5:0] dec_op, dec_fn;
   logic [6:0] dec_st;

   instr_decoder u_dec (
      .opcode (dec_op),
      .funct  (dec_fn),
      .state  (dec_st)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [2:0] sel, input string tag, input logic [6:0] exp);
      bus.nextSel = sel;
      @(posedge clk);
      #1;
      chk(tag, bus.currentState, exp);
   endtask

   task automatic dchk(input logic [5:0] op, input logic [5:0] fn, input logic [6:0] exp);
      dec_op = op;
      dec_fn = fn;
      #1;
      chk($sformatf("dec_%02h_%02h", op, fn), dec_st, exp);
   endtask

   initial begin
      reset        = 1'b1;
      bus.nextSel  = 3'b010;
      bus.crAddr   = 7'd99;
      bus.condSel  = 2'b00;
      bus.condInv  = 1'b0;
      bus.moc      = 1'b0;
      bus.zeroFlag = 1'b0;
      bus.negFlag  = 1'b0;
      bus.opcode   = 6'h00;
      bus.funct    = 6'h00;
      dec_op       = 6'h00;
      dec_fn       = 6'h00;

      #2;
      chk("reset_value", bus.currentState, 7'd0);
      @(posedge clk); #1;
      chk("reset_hold", bus.currentState, 7'd0);
      reset = 1'b0;

      // Decoder table standalone
      dchk(6'h00, 6'h21, 7'd17);
      dchk(6'h00, 6'h23, 7'd18);
      dchk(6'h00, 6'h24, 7'd23);
      dchk(6'h00, 6'h25, 7'd25);
      dchk(6'h00, 6'h08, 7'd30);
      dchk(6'h00, 6'h3F, 7'd5);
      dchk(6'h23, 6'h21, 7'd7);
      dchk(6'h2B, 6'h00, 7'd9);
      dchk(6'h04, 6'h00, 7'd16);
      dchk(6'h09, 6'h00, 7'd6);
      dchk(6'h0F, 6'h00, 7'd31);
      dchk(6'h02, 6'h00, 7'd12);
      dchk(6'h3F, 6'h21, 7'd5);

      // Decode through the sequencer
      bus.opcode = 6'h23;
      step(3'b000, "decode_lw", 7'd7);
      bus.opcode = 6'h00; bus.funct = 6'h21;
      step(3'b000, "decode_addu", 7'd17);
      bus.opcode = 6'h3F;
      step(3'b000, "decode_illegal", 7'd5);

      // Increment and wrap
      bus.crAddr = 7'd3;
      step(3'b010, "cr_3", 7'd3);
      step(3'b011, "inc_4", 7'd4);
      bus.crAddr = 7'd127;
      step(3'b010, "cr_127", 7'd127);
      step(3'b011, "inc_wrap", 7'd0);

      // MOC polling
      bus.crAddr = 7'd8;
      step(3'b010, "cr_8", 7'd8);
      bus.condSel = 2'b00; bus.moc = 1'b0;
      for (int i = 0; i < 3; i++) step(3'b101, "wait_hold", 7'd8);
      bus.moc = 1'b1;
      step(3'b101, "wait_done", 7'd9);
      bus.moc = 1'b0;

      // Branches over each condition source
      bus.condSel = 2'b01; bus.crAddr = 7'd20; bus.zeroFlag = 1'b1; bus.condInv = 1'b0;
      step(3'b100, "br_zero_taken", 7'd20);
      bus.condInv = 1'b1;
      step(3'b100, "br_zero_inv", 7'd21);
      bus.condInv = 1'b0; bus.condSel = 2'b10; bus.crAddr = 7'd50; bus.negFlag = 1'b0;
      step(3'b100, "br_neg_not", 7'd22);
      bus.negFlag = 1'b1;
      step(3'b100, "br_neg_taken", 7'd50);
      bus.condSel = 2'b11; bus.crAddr = 7'd60;
      step(3'b100, "br_one", 7'd60);
      bus.condInv = 1'b1;
      step(3'b100, "br_one_inv", 7'd61);
      step(3'b101, "wait_never", 7'd61);
      bus.condInv = 1'b0;
      step(3'b001, "fetch", 7'd0);

      // Call / return
      bus.crAddr = 7'd10;
      step(3'b010, "cr_10", 7'd10);
      bus.crAddr = 7'd40;
`ifdef MICROSEQ_RETURN_EN
      step(3'b110, "call_40", 7'd40);
      step(3'b011, "sub_inc", 7'd41);
      step(3'b111, "ret_11", 7'd11);
      bus.crAddr = 7'd70;
      step(3'b110, "call_70", 7'd70);
      bus.crAddr = 7'd80;
      step(3'b110, "call_over", 7'd80);
      step(3'b111, "ret_71", 7'd71);
      step(3'b111, "ret_again", 7'd71);
`else
      step(3'b110, "call_off", 7'd0);
      bus.crAddr = 7'd33;
      step(3'b010, "cr_33", 7'd33);
      step(3'b111, "ret_off", 7'd0);
`endif

      // Asynchronous reset mid-cycle
      bus.crAddr = 7'd12;
      step(3'b010, "cr_12", 7'd12);
      bus.nextSel = 3'b011;
      #3;
      reset = 1'b1;
      #1;
      chk("async_reset", bus.currentState, 7'd0);
      @(posedge clk); #1;
      chk("reset_hold2", bus.currentState, 7'd0);
      reset = 1'b0;
      step(3'b011, "after_reset", 7'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-state generator for the microprogrammed MIPS control unit. Sits directly upstream of the microstore and owns the 7-bit state register that drives the microstore's `currentState` input.
- Each cycle it picks the next microstate from one of: the instruction decoder, a fixed fetch address, the control-register (CR) target, an increment, or a condition-gated branch. The select and branch fields come from the current microinstruction.

Parameters:
- STATE_W, 7, microstate width (matches the microstore address).
- FETCH_STATE, 7'd0, state entered on reset and on select 001.
- ILLEGAL_STATE, 7'd5, decoder output for any unmapped opcode/funct.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; forces `currentState` to FETCH_STATE.
- nextSel  input  3  next-state select field from the microinstruction.
- crAddr  input  7  CR target field from the microinstruction.
- condSel  input  2  condition mux select: 00 moc, 01 zeroFlag, 10 negFlag, 11 constant 1.
- condInv  input  1  inverts the selected condition.
- moc  input  1  memory-operation-complete from the RAM interface.
- zeroFlag  input  1  ALU zero flag (registered by the datapath).
- negFlag  input  1  ALU negative flag (registered by the datapath).
- opcode  input  6  IR[31:26].
- funct  input  6  IR[5:0].
- currentState  output  7  registered microstate, feeds the microstore.

Behaviour:
- Reset: asynchronous and active-high. `currentState` = FETCH_STATE and returnReg = 0 immediately; both hold while reset is high.
  - Deasserting reset mid-instruction always restarts at fetch.
- Latency: `currentState` updates on every rising clk edge; there is no enable.
  - The microstore is combinational, so control signals are valid in the same cycle as the new state.
- Condition: cond = mux(condSel) XOR condInv.
- inc = `currentState` + 1, modulo 2^7 (127 wraps to 0).
- nextSel encoding:
  - 000: decoder output.
  - 001: FETCH_STATE.
  - 010: crAddr.
  - 011: inc.
  - 100: cond ? crAddr : inc.
  - 101: cond ? inc : `currentState` (wait state; used for MOC polling with condSel=00).
  - 110: call, only with the optional feature.
  - 111: return, only with the optional feature.
- Decoder, for opcode 0x00 (selected on funct):
  - funct 0x21 ADDU -> 17
  - funct 0x23 SUBU -> 18
  - funct 0x24 AND -> 23
  - funct 0x25 OR -> 25
  - funct 0x08 JR -> 30
  - any other funct -> ILLEGAL_STATE.
- Decoder, other opcodes:
  - 0x23 LW -> 7
  - 0x2B SW -> 9
  - 0x04 BEQ -> 16
  - 0x09 ADDIU -> 6
  - 0x0F LUI -> 31
  - 0x02 J -> 12
  - anything else -> ILLEGAL_STATE.
- Decoder timing: purely combinational on opcode/funct. IR must be stable in the cycle where nextSel=000.
- Inputs changing between edges have no effect; only values at the rising edge matter.
- X on nextSel: the next state is FETCH_STATE (default branch).

Optional Feature:
- Macro: MICROSEQ_RETURN_EN.
- Defined:
  - A 7-bit returnReg (one-deep micro-subroutine stack) is present.
  - 110 call: next = crAddr and returnReg <= inc, both in the same edge.
  - 111 return: next = returnReg, and returnReg is unchanged.
  - A call while already inside a subroutine overwrites returnReg; no nesting.
- Not defined:
  - No returnReg exists.
  - 110 and 111 both go to FETCH_STATE.

Decomposition:
- Shared package `microseq_pkg`:
  - nextSel encoding constants (NS_DECODE, NS_FETCH, NS_CR, NS_INC, NS_BRANCH, NS_WAIT, NS_CALL, NS_RET).
  - condSel constants.
  - opcode/funct constants.
  - The decoded state-number constants above.
- One sub-module: `instr_decoder` (combinational opcode/funct -> 7-bit state), so the mapping can be tested alone.
- The state register, condition mux and next-state mux stay in the top module.

Test Plan:
- Reset: assert reset mid-cycle with `currentState`=12 -> `currentState`=0 immediately, without waiting for a clock edge; holds 0 until reset drops.
- Decode: nextSel=000, opcode=0x23 -> next edge gives 7. Opcode=0x00, funct=0x21 -> 17. Opcode=0x3F -> 5.
- Increment/wrap: nextSel=011 from 3 -> 4. Drive `currentState`=127 via crAddr=127 (nextSel=010), then nextSel=011 -> 0.
- MOC wait: nextSel=101, condSel=00, state 8, moc=0 for 3 cycles -> stays 8. moc=1 -> 9 on the next edge.
- Branch with inversion: nextSel=100, condSel=01, crAddr=20, zeroFlag=1, condInv=0 -> 20. Same with condInv=1 -> inc.
- Call/return (MICROSEQ_RETURN_EN):
  - At state 10, nextSel=110, crAddr=40 -> 40 and returnReg=11.
  - Later nextSel=111 -> 11.
  - Without the macro: 110 -> 0.
